// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Contents: access-size encoding, FSM state encoding, data/byte-enable widths.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    // Access size as presented on req_size
    typedef enum logic [1:0] {
        SIZE_B = 2'b00,
        SIZE_H = 2'b01,
        SIZE_W = 2'b10,
        SIZE_R = 2'b11
    } lsu_size_e;

    // Request sequencing: one accepted request walks IDLE -> ACCESS -> RESP
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_RESP   = 2'b10
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane formatting for the load/store unit.
// Optional macro: LSU_MISALIGN_TRAP_EN (flag misaligned/reserved accesses
// instead of silently aligning them).
// Ports:
//   i_size, i_addr_lo, i_unsigned : access attributes
//   i_wdata / o_wdata             : right-justified store data / lane-replicated
//   i_rdata / o_rdata             : raw memory word / shifted + extended load data
//   o_addr_lo                     : effective low address bits after alignment
//   o_be                          : byte enables for the effective access
//   o_misalign                    : access faults (always 0 without the macro)
module lsu_align
    import lsu_pkg::*;
(
    input  lsu_size_e         i_size,
    input  logic [1:0]        i_addr_lo,
    input  logic              i_unsigned,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [DATA_W-1:0] i_rdata,
    output logic [1:0]        o_addr_lo,
    output logic              o_misalign,
    output logic [BE_W-1:0]   o_be,
    output logic [DATA_W-1:0] o_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    lsu_size_e         w_size;
    logic [DATA_W-1:0] w_shifted;

    // Effective size/address and fault detection
    always_comb begin
`ifdef LSU_MISALIGN_TRAP_EN
        w_size     = i_size;
        o_addr_lo  = i_addr_lo;
        o_misalign = (i_size == SIZE_R)
                   || ((i_size == SIZE_H) && i_addr_lo[0])
                   || ((i_size == SIZE_W) && (i_addr_lo != 2'b00));
`else
        w_size     = (i_size == SIZE_R) ? SIZE_W : i_size;
        o_misalign = 1'b0;
        case (w_size)
            SIZE_H:  o_addr_lo = {i_addr_lo[1], 1'b0};
            SIZE_B:  o_addr_lo = i_addr_lo;
            default: o_addr_lo = 2'b00;
        endcase
`endif
    end

    assign w_shifted = i_rdata >> {o_addr_lo, 3'b000};

    // Byte enables, store replication and load extension
    always_comb begin
        o_be    = '0;
        o_wdata = '0;
        o_rdata = '0;
        case (w_size)
            SIZE_B: begin
                o_be    = 4'b0001 << o_addr_lo;
                o_wdata = {4{i_wdata[7:0]}};
                o_rdata = i_unsigned ? {24'd0, w_shifted[7:0]}
                                     : {{24{w_shifted[7]}}, w_shifted[7:0]};
            end
            SIZE_H: begin
                o_be    = o_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_wdata[15:0]}};
                o_rdata = i_unsigned ? {16'd0, w_shifted[15:0]}
                                     : {{16{w_shifted[15]}}, w_shifted[15:0]};
            end
            default: begin
                o_be    = 4'b1111;
                o_wdata = i_wdata;
                o_rdata = w_shifted;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: accepts one core request at a time and drives a
// synchronous-read memory port, returning a one-cycle response two cycles
// after acceptance.
// Optional macro: LSU_MISALIGN_TRAP_EN (fault misaligned / reserved-size
// requests; otherwise they are aligned down and resp_fault stays 0).
// Ports:
//   clk, rst_n               : clock, synchronous active-low reset
//   req_*                    : core request handshake and attributes
//   resp_valid/rdata/fault   : response strobe, formatted load data, fault
//   mem_addr/wdata/be/we     : memory port B request (valid during ACCESS)
//   mem_rdata                : memory port B read data (valid during RESP)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter  int unsigned MEM_SIZE = 8192,
    localparam int unsigned AW       = $clog2(MEM_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [AW-1:0]     req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [BE_W-1:0]   mem_be,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    lsu_state_e        r_state;
    lsu_state_e        w_state_nxt;
    logic              w_accept;

    logic              r_ready;
    logic              r_write;
    lsu_size_e         r_size;
    logic              r_unsigned;
    logic [1:0]        r_addr_lo;
    logic              r_fault;
    logic              r_resp_valid;
    logic              r_resp_fault;
    logic [AW-1:0]     r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [BE_W-1:0]   r_mem_be;
    logic              r_mem_we;

    logic              w_idle;
    lsu_size_e         w_size;
    logic [1:0]        w_addr_lo;
    logic              w_unsigned;
    logic [1:0]        w_eff_lo;
    logic              w_misalign;
    logic [BE_W-1:0]   w_be;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rdata;

    // One formatter serves both phases: live request in IDLE, captured fields after
    assign w_idle     = (r_state == ST_IDLE);
    assign w_size     = w_idle ? lsu_size_e'(req_size) : r_size;
    assign w_addr_lo  = w_idle ? req_addr[1:0] : r_addr_lo;
    assign w_unsigned = w_idle ? req_unsigned : r_unsigned;

    lsu_align u_align (
        .i_size     (w_size),
        .i_addr_lo  (w_addr_lo),
        .i_unsigned (w_unsigned),
        .i_wdata    (req_wdata),
        .i_rdata    (mem_rdata),
        .o_addr_lo  (w_eff_lo),
        .o_misalign (w_misalign),
        .o_be       (w_be),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (req_valid && r_ready) begin
                    w_accept    = 1'b1;
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_nxt = ST_RESP;
            ST_RESP:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture, memory port and response registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ready      <= 1'b0;
            r_write      <= 1'b0;
            r_size       <= SIZE_B;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'b00;
            r_fault      <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_fault <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_be     <= '0;
            r_mem_we     <= 1'b0;
        end else begin
            r_ready      <= (w_state_nxt == ST_IDLE);
            r_resp_valid <= (r_state == ST_ACCESS);
            r_resp_fault <= (r_state == ST_ACCESS) && r_fault;
            if (w_accept) begin
                r_write     <= req_write;
                r_size      <= lsu_size_e'(req_size);
                r_unsigned  <= req_unsigned;
                r_addr_lo   <= w_eff_lo;
                r_fault     <= w_misalign;
                r_mem_addr  <= {req_addr[AW-1:2], w_eff_lo};
                r_mem_wdata <= w_wdata;
                r_mem_be    <= w_misalign ? '0 : w_be;
                r_mem_we    <= req_write && !w_misalign;
            end else if (r_state == ST_ACCESS) begin
                r_mem_we <= 1'b0;
                r_mem_be <= '0;
            end
        end
    end

    assign req_ready  = r_ready;
    assign resp_valid = r_resp_valid;
    assign resp_fault = r_resp_fault;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_be     = r_mem_be;
    assign mem_we     = r_mem_we;

    // Read data only exists during RESP, so load formatting is applied on the fly
    assign resp_rdata = (r_resp_valid && !r_write && !r_resp_fault) ? w_rdata : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, throughput
// and reset sequences, and randomized traffic against a byte-array model.
module tb_load_store_unit;

    localparam int unsigned MEM_SIZE = 8192;
    localparam int unsigned AW       = $clog2(MEM_SIZE);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid, req_ready, req_write, req_unsigned;
    logic [1:0]    req_size;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid, resp_fault;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_be;
    logic          mem_we;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    load_store_unit #(.MEM_SIZE(MEM_SIZE)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_fault(resp_fault),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    // Attached synchronous memory (port B)
    logic [31:0] tb_mem [0:MEM_SIZE/4-1];
    always @(posedge clk) begin
        if (mem_we)
            for (int k = 0; k < 4; k++)
                if (mem_be[k]) tb_mem[mem_addr[AW-1:2]][8*k +: 8] <= mem_wdata[8*k +: 8];
        mem_rdata <= tb_mem[mem_addr[AW-1:2]];
    end

    // Reference model: flat byte memory
    logic [7:0] ref_mem [0:MEM_SIZE-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic ref_op(input bit wr, input logic [1:0] sz, input bit uns, input int addr,
                          input logic [31:0] wd, output logic [31:0] e_rd, output bit e_fault,
                          output logic [3:0] e_be, output int e_addr, output logic [31:0] e_wd);
        int n;
        int a;
        logic [31:0] val;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
        e_fault = ((addr % n) != 0) || (sz == 2'd3);
        a = addr;
`else
        e_fault = 1'b0;
        a = addr - (addr % n);
`endif
        e_addr = a;
        e_rd = 32'd0;
        e_be = 4'd0;
        for (int k = 0; k < 4; k++) e_wd[8*k +: 8] = wd[8*(k % n) +: 8];
        if (!e_fault) begin
            for (int i = 0; i < n; i++) e_be[(a % 4) + i] = 1'b1;
            if (wr) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < n; i++) val = val | (32'(ref_mem[a + i]) << (8*i));
                if (!uns && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
                e_rd = val;
            end
        end
    endtask

    // One request: wait for ready, accept, sample ACCESS then RESP (negedge sampling)
    logic        o_we, o_rv_acc, o_rv, o_fault, o_ok;
    logic [3:0]  o_be;
    logic [31:0] o_addr, o_wd, o_rd;

    task automatic do_req(input bit wr, input logic [1:0] sz, input bit uns,
                          input int addr, input logic [31:0] wd);
        int waited;
        waited = 0;
        o_ok = 1'b1;
        while (!req_ready && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 32'(req_ready), 32'd1);
            o_ok = 1'b0;
            return;
        end
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = AW'(addr); req_wdata = wd;
        @(negedge clk);
        o_we = mem_we; o_be = mem_be; o_addr = 32'(mem_addr); o_wd = mem_wdata;
        o_rv_acc = resp_valid;
        req_valid = 1'b0;
        req_write = ~wr; req_size = ~sz; req_addr = ~AW'(addr); req_wdata = ~wd;
        @(negedge clk);
        o_rv = resp_valid; o_rd = resp_rdata; o_fault = resp_fault;
        @(negedge clk);
        chk("resp_one_cycle", 32'(resp_valid), 32'd0);
    endtask

    typedef struct {
        string       name;
        bit          wr;
        logic [1:0]  sz;
        bit          uns;
        int          addr;
        logic [31:0] wd;
        logic [31:0] e_rd;
        bit          e_fault;
        logic [3:0]  e_be;
        bit          e_we;
        int          e_addr;
    } vec_t;

    vec_t vecs [12];

    task automatic setv(input int i, input string nm, input bit wr, input logic [1:0] sz,
                        input bit uns, input int addr, input logic [31:0] wd,
                        input logic [31:0] e_rd, input bit e_fault, input logic [3:0] e_be,
                        input bit e_we, input int e_addr);
        vecs[i] = '{nm, wr, sz, uns, addr, wd, e_rd, e_fault, e_be, e_we, e_addr};
    endtask

    initial begin
        for (int i = 0; i < MEM_SIZE/4; i++) tb_mem[i] = 32'd0;
        for (int i = 0; i < MEM_SIZE; i++) ref_mem[i] = 8'd0;

        setv(0,  "st_w_dead",  1, 2'd2, 0, 'h10, 32'hDEADBEEF, 32'h0, 0, 4'b1111, 1, 'h10);
        setv(1,  "st_b_a5",    1, 2'd0, 0, 'h13, 32'h000000A5, 32'h0, 0, 4'b1000, 1, 'h13);
        setv(2,  "ld_b_s",     0, 2'd0, 0, 'h13, 32'h0, 32'hFFFFFFA5, 0, 4'b1000, 0, 'h13);
        setv(3,  "ld_b_u",     0, 2'd0, 1, 'h13, 32'h0, 32'h000000A5, 0, 4'b1000, 0, 'h13);
        setv(4,  "st_w_8001",  1, 2'd2, 0, 'h00, 32'h80017FFF, 32'h0, 0, 4'b1111, 1, 'h00);
        setv(5,  "ld_h_hi",    0, 2'd1, 0, 'h02, 32'h0, 32'hFFFF8001, 0, 4'b1100, 0, 'h02);
        setv(6,  "ld_h_lo",    0, 2'd1, 0, 'h00, 32'h0, 32'h00007FFF, 0, 4'b0011, 0, 'h00);
        setv(7,  "ld_w_mix",   0, 2'd2, 0, 'h10, 32'h0, 32'hA5ADBEEF, 0, 4'b1111, 0, 'h10);
`ifdef LSU_MISALIGN_TRAP_EN
        setv(8,  "st_w_mis",   1, 2'd2, 0, 'h12, 32'h11223344, 32'h0, 1, 4'b0000, 0, 'h12);
        setv(9,  "ld_w_after", 0, 2'd2, 0, 'h10, 32'h0, 32'hA5ADBEEF, 0, 4'b1111, 0, 'h10);
        setv(10, "ld_h_odd",   0, 2'd1, 1, 'h03, 32'h0, 32'h0, 1, 4'b0000, 0, 'h03);
        setv(11, "ld_rsvd",    0, 2'd3, 0, 'h10, 32'h0, 32'h0, 1, 4'b0000, 0, 'h10);
`else
        setv(8,  "st_w_mis",   1, 2'd2, 0, 'h12, 32'h11223344, 32'h0, 0, 4'b1111, 1, 'h10);
        setv(9,  "ld_w_after", 0, 2'd2, 0, 'h10, 32'h0, 32'h11223344, 0, 4'b1111, 0, 'h10);
        setv(10, "ld_h_odd",   0, 2'd1, 1, 'h03, 32'h0, 32'h00008001, 0, 4'b1100, 0, 'h02);
        setv(11, "ld_rsvd",    0, 2'd3, 0, 'h10, 32'h0, 32'h11223344, 0, 4'b1111, 0, 'h10);
`endif

        // Reset state
        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'd0;
        req_unsigned = 1'b0; req_addr = '0; req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_outputs", {26'd0, mem_we, resp_fault, mem_be}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 32'(req_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 12; i++) begin
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd);
            if (!o_ok) continue;
            chk({vecs[i].name, "_acc_rv"}, 32'(o_rv_acc), 32'd0);
            chk({vecs[i].name, "_we"}, 32'(o_we), 32'(vecs[i].e_we));
            chk({vecs[i].name, "_be"}, 32'(o_be), 32'(vecs[i].e_be));
            if (!vecs[i].e_fault) chk({vecs[i].name, "_addr"}, o_addr, vecs[i].e_addr);
            chk({vecs[i].name, "_resp_valid"}, 32'(o_rv), 32'd1);
            chk({vecs[i].name, "_rdata"}, o_rd, vecs[i].e_rd);
            chk({vecs[i].name, "_fault"}, 32'(o_fault), 32'(vecs[i].e_fault));
        end
        chk("st_b_repl", 32'hA5A5A5A5, 32'hA5A5A5A5 & {32{1'b1}});
        do_req(1, 2'd0, 0, 'h40, 32'h123456A5);
        chk("st_b_wdata", o_wd, 32'hA5A5A5A5);
        do_req(1, 2'd1, 0, 'h42, 32'h9876BEEF);
        chk("st_h_wdata", o_wd, 32'hBEEFBEEF);

        // Held req_valid: accepts only every third cycle
        begin
            int accepts;
            accepts = 0;
            req_valid = 1'b1; req_write = 1'b0; req_size = 2'd2; req_addr = AW'(32'h20);
            for (int c = 0; c < 6; c++) begin
                chk($sformatf("hold_ready_c%0d", c), 32'(req_ready), 32'((c % 3) == 0));
                if (req_ready) accepts++;
                @(negedge clk);
            end
            req_valid = 1'b0;
            chk("hold_accepts", 32'(accepts), 32'd2);
        end

        // Randomized traffic against the byte model, in a region untouched above
        for (int t = 0; t < 150; t++) begin
            bit wr, uns, ef;
            logic [1:0] sz;
            int addr, ea;
            logic [31:0] wd, erd, ewd;
            logic [3:0] ebe;
            wr = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(0, 3));
            addr = 'h100 + int'($urandom_range(0, 63));
            wd = $urandom;
            ref_op(wr, sz, uns, addr, wd, erd, ef, ebe, ea, ewd);
            do_req(wr, sz, uns, addr, wd);
            if (!o_ok) continue;
            chk($sformatf("rnd%0d_rv", t), 32'(o_rv), 32'd1);
            chk($sformatf("rnd%0d_rdata", t), o_rd, erd);
            chk($sformatf("rnd%0d_fault", t), 32'(o_fault), 32'(ef));
            chk($sformatf("rnd%0d_be", t), 32'(o_be), 32'(ebe));
            chk($sformatf("rnd%0d_we", t), 32'(o_we), 32'(wr && !ef));
            if (!ef) chk($sformatf("rnd%0d_addr", t), o_addr, ea);
            if (wr && !ef) chk($sformatf("rnd%0d_wdata", t), o_wd, ewd);
        end

        // Reset during ACCESS of a store aborts the response
        if (!req_ready) @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd2; req_addr = AW'(32'h200);
        req_wdata = 32'hCAFEF00D;
        @(negedge clk);
        chk("abort_access_we", 32'(mem_we), 32'd1);
        rst_n = 1'b0; req_valid = 1'b0;
        @(negedge clk);
        chk("abort_rv0", 32'(resp_valid), 32'd0);
        chk("abort_ready0", 32'(req_ready), 32'd0);
        chk("abort_we0", 32'(mem_we), 32'd0);
        @(negedge clk);
        chk("abort_rv1", 32'(resp_valid), 32'd0);
        chk("abort_ready1", 32'(req_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_ready_release", 32'(req_ready), 32'd1);
        chk("abort_rv_release", 32'(resp_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter: MEM_SIZE, 8192, bytes of attached memory; address width AW = $clog2(MEM_SIZE).
REQ-002 SHALL have ports, clock and reset first:
  clk  in  1  sole clock; all state updates on rising edge.
  rst_n  in  1  reset, synchronous, active-low.
  req_valid  in  1  core request present.
  req_ready  out  1  unit accepts a request this cycle.
  req_write  in  1  1 = store, 0 = load.
  req_size  in  2  00 byte, 01 half, 10 word, 11 reserved.
  req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
  req_addr  in  AW  byte address.
  req_wdata  in  32  store data, right-justified.
  resp_valid  out  1  one-cycle response strobe; no backpressure.
  resp_rdata  out  32  formatted load data; 0 for stores.
  resp_fault  out  1  request faulted (see Configuration).
  mem_addr  out  AW  to memory port B address.
  mem_wdata  out  32  to memory port B write data.
  mem_be  out  4  to memory port B byte enables.
  mem_we  out  1  to memory port B write enable.
  mem_rdata  in  32  from memory port B; valid one cycle after address sampled.

Function
REQ-003 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE; unconditional except IDLE.
REQ-004 SHALL assert req_ready only in IDLE; accept on req_valid && req_ready (cycle N).
REQ-005 SHALL register mem_addr/mem_be/mem_wdata/mem_we at the accept edge; they are valid throughout ACCESS (cycle N+1).
REQ-006 SHALL assert mem_we for exactly the ACCESS cycle of a non-faulting store; 0 in all other states.
REQ-007 SHALL drive mem_be: byte = 1 << addr[1:0]; half = addr[1] ? 1100 : 0011; word = 1111.
REQ-008 SHALL replicate store data: byte {4{wdata[7:0]}}, half {2{wdata[15:0]}}, word wdata.
REQ-009 SHALL assert resp_valid for one cycle in RESP (cycle N+2) for every accepted request, loads and stores alike.
REQ-010 SHALL form resp_rdata from mem_rdata >> (8*addr[1:0]), truncated to size and extended per req_unsigned; 0 for stores.
REQ-011 SHALL ignore req_valid, and all req_* values, outside IDLE; captured request fields are held until RESP completes.
REQ-012 SHALL sustain a throughput of one request per 3 cycles; back-to-back req_valid is next accepted in the cycle after RESP.

Reset
REQ-013 SHALL, while rst_n = 0 at a clock edge, force state IDLE and all outputs to 0, including req_ready.
REQ-014 SHALL assert req_ready in the first cycle after rst_n rises.
REQ-015 SHALL, on reset during ACCESS or RESP, abort the request: no resp_valid, mem_we = 0 from the next edge.

Configuration
REQ-016 SHALL provide macro LSU_MISALIGN_TRAP_EN.
REQ-017 With LSU_MISALIGN_TRAP_EN defined: half at odd address, word with addr[1:0] != 0, or size 11 SHALL fault; mem_we and mem_be stay 0; RESP at N+2 with resp_fault = 1, resp_rdata = 0.
REQ-018 Without LSU_MISALIGN_TRAP_EN: resp_fault SHALL be tied 0; half clears addr[0], word clears addr[1:0], size 11 is treated as word.

Structure
REQ-019 SHALL place the size encoding enum, FSM state enum and constants (SIZE_B/H/W) in shared package lsu_pkg.
REQ-020 SHALL place combinational be/wdata/rdata formatting in sub-module lsu_align; load_store_unit holds the FSM and registers.

Verification
REQ-021 Store word 0xDEADBEEF @0x10 -> ACCESS cycle: mem_addr 0x10, be 1111, we 1; resp_valid at N+2, rdata 0.
REQ-022 Store byte 0xA5 @0x13 -> be 1000, wdata 0xA5A5A5A5; then load byte signed @0x13 -> rdata 0xFFFFFFA5; unsigned -> 0x000000A5.
REQ-023 Memory word 0x8001_7FFF: load half signed @0x2 -> 0xFFFF8001; @0x0 -> 0x00007FFF.
REQ-024 Held req_valid for 6 cycles -> exactly 2 accepts, req_ready high only in cycles 0 and 3.
REQ-025 Word store @0x12 -> with macro: fault, we 0, memory unchanged; without macro: writes @0x10, resp_fault 0.
REQ-026 rst_n low during ACCESS of a store -> no resp_valid, req_ready 0 while reset, 1 the cycle after release.
